// File: rtl/regbank_arb_pkg.sv
// rtl/regbank_arb_pkg.sv - shared constants and types for the register bank writeback arbiter
package regbank_arb_pkg;

  localparam int REG_AW  = 4;
  localparam int REG_DW  = 32;
  localparam int REG_NUM = 16;

  typedef logic [REG_AW-1:0]  reg_addr_t;
  typedef logic [REG_DW-1:0]  reg_data_t;
  typedef logic [REG_NUM-1:0] busy_vec_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, one-hot grant
//
// Grants the first asserted req at or after ptr, wrapping around.
// The pointer register lives in the instantiating module.
//   req  in  N   request vector
//   ptr  in  PW  index of highest-priority requester
//   en   in  1   0 forces gnt to all zeros
//   gnt  out N   one-hot grant (or zero)
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_wb_arb.sv
// rtl/regbank_wb_arb.sv - writeback arbiter and busy scoreboard for the 16x32 register bank
//
// Arbitrates NREQ writeback requesters onto the single bank write port through
// a registered output stage, and keeps one busy bit per register for RAW checks.
// Optional macro REGBANK_WB_ARB_FWD_EN adds a write-to-read forwarding mux and
// lets busy1/busy2 drop during the cycle the value is being written.
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/addr/data     requester i: valid, dest [i*AW +: AW], data [i*DW +: DW]
//   req_ready               one-hot grant
//   wr_hold                 stall: grant nothing
//   rsv_en, rsv_addr        issue-time reservation of a destination register
//   chk_ra1/2, busy1/2      hazard check addresses and their busy status
//   rsv_err                 sticky: reservation of an already-busy register
//   w_en, wa, wd            registered bank write port
//   ra1/2_in, rd1/2_in, rd1/2_out   forwarding path (REGBANK_WB_ARB_FWD_EN only)
module regbank_wb_arb
  import regbank_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = REG_AW,
  parameter int DW   = REG_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              wr_hold,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [AW-1:0]     chk_ra1,
  input  logic [AW-1:0]     chk_ra2,
  output logic              busy1,
  output logic              busy2,
  output logic              rsv_err,
`ifdef REGBANK_WB_ARB_FWD_EN
  input  logic [AW-1:0]     ra1_in,
  input  logic [AW-1:0]     ra2_in,
  input  logic [DW-1:0]     rd1_in,
  input  logic [DW-1:0]     rd2_in,
  output logic [DW-1:0]     rd1_out,
  output logic [DW-1:0]     rd2_out,
`endif
  output logic              w_en,
  output logic [AW-1:0]     wa,
  output logic [DW-1:0]     wd
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 1 << AW;

  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic [PW-1:0]   win_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_nxt;
  logic            rsv_clr;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .en  (rst_n && !wr_hold),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    win_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  // Clear on the write edge, then apply the reservation so a same-edge
  // re-reservation of the register being written keeps it busy.
  assign rsv_clr = w_en && (wa == rsv_addr);

  always_comb begin
    busy_nxt = busy_q;
    if (w_en)   busy_nxt[wa]       = 1'b0;
    if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_en    <= 1'b0;
      wa      <= '0;
      wd      <= '0;
      rsv_err <= 1'b0;
      busy_q  <= '0;
      ptr_q   <= '0;
    end else begin
      w_en   <= xfer;
      busy_q <= busy_nxt;
      if (xfer) begin
        wa    <= sel_addr;
        wd    <= sel_data;
        ptr_q <= (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
      if (rsv_en && busy_q[rsv_addr] && !rsv_clr) rsv_err <= 1'b1;
    end
  end

`ifdef REGBANK_WB_ARB_FWD_EN
  // The value being written this cycle is forwarded, so the consumer need not wait.
  assign busy1   = busy_q[chk_ra1] && !(w_en && (wa == chk_ra1));
  assign busy2   = busy_q[chk_ra2] && !(w_en && (wa == chk_ra2));
  assign rd1_out = (w_en && (wa == ra1_in)) ? wd : rd1_in;
  assign rd2_out = (w_en && (wa == ra2_in)) ? wd : rd2_in;
`else
  assign busy1 = busy_q[chk_ra1];
  assign busy2 = busy_q[chk_ra2];
`endif

endmodule

// File: tb/tb_regbank_wb_arb.sv
// tb/tb_regbank_wb_arb.sv - self-checking bench for regbank_wb_arb with write scoreboard
module tb_regbank_wb_arb;

  localparam int NREQ = 3;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wr_hold;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [AW-1:0]     chk_ra1;
  logic [AW-1:0]     chk_ra2;
  logic              busy1;
  logic              busy2;
  logic              rsv_err;
  logic              w_en;
  logic [AW-1:0]     wa;
  logic [DW-1:0]     wd;
`ifdef REGBANK_WB_ARB_FWD_EN
  logic [AW-1:0]     ra1_in;
  logic [AW-1:0]     ra2_in;
  logic [DW-1:0]     rd1_in;
  logic [DW-1:0]     rd2_in;
  logic [DW-1:0]     rd1_out;
  logic [DW-1:0]     rd2_out;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic          pend   = 1'b0;
  int            ptr_m  = 0;
  logic [NREQ-1:0] exp_g;

  always #5 clk = ~clk;

  regbank_wb_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_hold   (wr_hold),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .chk_ra1   (chk_ra1),
    .chk_ra2   (chk_ra2),
    .busy1     (busy1),
    .busy2     (busy2),
    .rsv_err   (rsv_err),
`ifdef REGBANK_WB_ARB_FWD_EN
    .ra1_in    (ra1_in),
    .ra2_in    (ra2_in),
    .rd1_in    (rd1_in),
    .rd2_in    (rd2_in),
    .rd1_out   (rd1_out),
    .rd2_out   (rd2_out),
`endif
    .w_en      (w_en),
    .wa        (wa),
    .wd        (wd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] model_gnt();
    logic [NREQ-1:0] g;
    g = '0;
    if (rst_n && !wr_hold) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        int idx;
        idx = (ptr_m + k) % NREQ;
        if (req_valid[idx]) g = NREQ'(1) << idx;
      end
    end
    return g;
  endfunction

  // Scoreboard: grants push the expected write, the following cycle pops it.
  always @(negedge clk) begin
    wr_t e;
    exp_g = model_gnt();
    check("req_ready", 64'(req_ready), 64'(exp_g));
    if (pend) begin
      check("w_en_hi", 64'(w_en), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wa", 64'(wa), 64'(e.addr));
        check("wd", 64'(wd), 64'(e.data));
      end else begin
        check("sb_underflow", 64'd1, 64'd0);
      end
    end else begin
      check("w_en_lo", 64'(w_en), 64'd0);
    end
    if (!rst_n) begin
      ptr_m = 0;
      pend  = 1'b0;
      exp_q.delete();
    end else begin
      pend = |exp_g;
      for (int i = 0; i < NREQ; i++) begin
        if (exp_g[i]) begin
          e.addr = req_addr[i*AW +: AW];
          e.data = req_data[i*DW +: DW];
          exp_q.push_back(e);
          ptr_m = (i + 1) % NREQ;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 3'b111;
    req_addr  = {4'd3, 4'd2, 4'd1};
    req_data  = {32'd30, 32'd20, 32'd10};
    wr_hold   = 1'b0;
    rsv_en    = 1'b0;
    rsv_addr  = '0;
    chk_ra1   = 4'd5;
    chk_ra2   = 4'd7;
`ifdef REGBANK_WB_ARB_FWD_EN
    ra1_in = '0;
    ra2_in = 4'd15;
    rd1_in = '0;
    rd2_in = 32'hCAFE;
`endif

    // reset with everything requesting
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_w_en", 64'(w_en), 64'd0);
      check("rst_wa", 64'(wa), 64'd0);
      check("rst_wd", 64'(wd), 64'd0);
      check("rst_busy1", 64'(busy1), 64'd0);
      check("rst_busy2", 64'(busy2), 64'd0);
    end
    step();
    rst_n = 1'b1;

    // round robin, continuous requests
    @(negedge clk);
    check("rr_first", 64'(req_ready), 64'b001);
    repeat (7) step();
    req_valid = '0;
    repeat (2) step();

    // hazard on reg 5
    rsv_en   = 1'b1;
    rsv_addr = 4'd5;
    step();
    rsv_en    = 1'b0;
    req_valid = 3'b010;
    req_addr[1*AW +: AW] = 4'd5;
    req_data[1*DW +: DW] = 32'hA5;
    @(negedge clk);
    check("haz_busy_set", 64'(busy1), 64'd1);
    step();
    req_valid = '0;
    @(negedge clk);
`ifdef REGBANK_WB_ARB_FWD_EN
    check("haz_busy_wr", 64'(busy1), 64'd0);
`else
    check("haz_busy_wr", 64'(busy1), 64'd1);
`endif
    step();
    @(negedge clk);
    check("haz_busy_clr", 64'(busy1), 64'd0);

    // stall with 0 and 1 requesting; pointer sits at 2
    step();
    wr_hold   = 1'b1;
    req_valid = 3'b011;
    repeat (3) begin
      @(negedge clk);
      check("hold_ready", 64'(req_ready), 64'd0);
      check("hold_w_en", 64'(w_en), 64'd0);
      step();
    end
    wr_hold = 1'b0;
    @(negedge clk);
    check("release_gnt", 64'(req_ready), 64'b001);
    step();
    @(negedge clk);
    check("release_gnt2", 64'(req_ready), 64'b010);
    step();
    req_valid = '0;
    step();

    // reserve 7, write 7, re-reserve at the write edge
    rsv_en   = 1'b1;
    rsv_addr = 4'd7;
    step();
    rsv_en    = 1'b0;
    req_valid = 3'b001;
    req_addr[0 +: AW] = 4'd7;
    req_data[0 +: DW] = 32'h77;
    step();
    req_valid = '0;
    rsv_en    = 1'b1;
    step();
    rsv_en = 1'b0;
    @(negedge clk);
    check("coll_busy", 64'(busy2), 64'd1);
    check("coll_no_err", 64'(rsv_err), 64'd0);
    step();
    rsv_en = 1'b1;
    step();
    rsv_en = 1'b0;
    @(negedge clk);
    check("err_set", 64'(rsv_err), 64'd1);
    repeat (3) step();
    @(negedge clk);
    check("err_sticky", 64'(rsv_err), 64'd1);
    check("busy_kept", 64'(busy2), 64'd1);

`ifdef REGBANK_WB_ARB_FWD_EN
    // forwarding mux
    req_valid = 3'b001;
    req_addr[0 +: AW] = 4'd4;
    req_data[0 +: DW] = 32'h1234;
    ra1_in = 4'd4;
    rd1_in = '0;
    step();
    req_valid = '0;
    @(negedge clk);
    check("fwd_hit", 64'(rd1_out), 64'h1234);
    check("fwd_rd2", 64'(rd2_out), 64'hCAFE);
    #1;
    ra1_in = 4'd3;
    rd1_in = 32'hDEAD;
    #1;
    check("fwd_miss", 64'(rd1_out), 64'hDEAD);
    step();
`endif

    // reset mid-operation
    req_valid = 3'b100;
    step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    check("rst2_rsv_err", 64'(rsv_err), 64'd0);
    check("rst2_busy2", 64'(busy2), 64'd0);
    check("rst2_w_en", 64'(w_en), 64'd0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
